// File: rtl/mem_port_arbiter.sv
// Multi-channel byte-serial memory port arbiter.
// Grants one requestor at a time (fixed priority or round-robin) and moves
// 1, 2 or 4 bytes through a single 8-bit memory port with one-cycle read latency.
module mem_port_arbiter #(
  parameter int NCH      = 2,
  parameter int ARB_MODE = 1,
  parameter int AW       = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH-1:0]      we_i,
  input  logic [2*NCH-1:0]    size_i,
  input  logic [AW*NCH-1:0]   addr_i,
  input  logic [32*NCH-1:0]   wdata_i,
  input  logic [NCH-1:0]      abort_i,
  output logic [NCH-1:0]      done_o,
  output logic [31:0]         rdata_o,
  output logic                busy_o,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [AW-1:0]       mem_a,
  output logic                mem_wr
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] win_q,   win_d;
  logic [IW-1:0] rr_q,    rr_d;
  logic          we_q,    we_d;
  logic [2:0]    n_q,     n_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    cnt_q,   cnt_d;
  logic          pend_q,  pend_d;

  logic [NCH-1:0] elig;
  logic           gnt_vld;
  logic [IW-1:0]  gnt_idx;
  logic           sel_we;
  logic [1:0]     sel_size;
  logic [AW-1:0]  sel_addr;
  logic [31:0]    sel_wdata;
  logic           ab_win;
  logic           issue;
  logic           capture;
  logic           fin_act;
  logic [1:0]     cidx;

  function automatic logic [2:0] bytes_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Winner selection; the channel completing in FIN is excluded from the search.
  // In fixed-priority mode a masked top-priority requestor blocks the FIN-cycle
  // grant instead of letting a lower channel slip in ahead of it.
  always_comb begin
    elig    = req_i;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == S_FIN) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (win_q == IW'(i)) elig[i] = 1'b0;
      end
    end
    if (ARB_MODE == 0) begin
      for (int unsigned i = NCH; i > 0; i--) begin
        if (req_i[i-1]) gnt_idx = IW'(i - 1);
      end
      gnt_vld = (|req_i) && !((state_q == S_FIN) && (gnt_idx == win_q));
    end else begin
      for (int unsigned off = 0; off < NCH; off++) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (!gnt_vld && elig[i] && (i == (32'(rr_q) + off) % NCH)) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(i);
          end
        end
      end
    end
  end

  // Per-channel field mux for the candidate winner and the current owner's abort.
  always_comb begin
    sel_we    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    ab_win    = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_we    = we_i[i];
        sel_size  = size_i[2*i +: 2];
        sel_addr  = addr_i[AW*i +: AW];
        sel_wdata = wdata_i[32*i +: 32];
      end
      if (win_q == IW'(i)) ab_win = abort_i[i];
    end
  end

  assign issue   = (state_q == S_XFER) && rdy_in && (cnt_q < n_q);
  assign capture = (state_q == S_XFER) && rdy_in && !we_q && pend_q;
  assign fin_act = (state_q == S_FIN) && rdy_in;
  assign cidx    = 2'(cnt_q - 3'd1);

  // Next-state logic; everything holds while rdy_in is low.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    we_d    = we_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE, S_FIN: begin
          state_d = S_IDLE;
          if (gnt_vld) begin
            state_d = S_XFER;
            win_d   = gnt_idx;
            rr_d    = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
            we_d    = sel_we;
            n_d     = bytes_of(sel_size);
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            rdata_d = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        end
        S_XFER: begin
          if (we_q) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == n_q - 3'd1) state_d = S_FIN;
          end else if (ab_win) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end else begin
            if (issue) cnt_d = cnt_q + 3'd1;
            pend_d = issue;
            if (capture) rdata_d[{cidx, 3'b000} +: 8] = mem_din;
            if (pend_q && (cnt_q == n_q)) state_d = S_FIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      we_q    <= 1'b0;
      n_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Memory-side and completion outputs. While stalled with a read capture
  // pending, the address of the byte awaiting capture is re-driven so its data
  // is still on mem_din when rdy_in returns.
  always_comb begin
    busy_o   = (state_q == S_XFER);
    mem_wr   = issue && we_q;
    mem_a    = '0;
    mem_dout = '0;
    if (state_q == S_XFER) begin
      mem_a = addr_q + AW'(cnt_q) - AW'(pend_q && !rdy_in);
      if (we_q) mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
    rdata_o = fin_act ? rdata_q : '0;
    done_o  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      done_o[i] = fin_act && (win_q == IW'(i));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single-channel transfers checked against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;

  // Round-robin instance: 3 channels, 16-bit addresses.
  logic [2:0]  req, we, abt, done;
  logic [5:0]  sz_v;
  logic [47:0] ad_v;
  logic [95:0] wd_v;
  logic [31:0] rdata;
  logic        busy, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [15:0] mem_a;

  // Fixed-priority instance: 2 channels.
  logic [1:0]  f_req, f_we, f_abt, f_done;
  logic [3:0]  f_sz;
  logic [31:0] f_ad;
  logic [63:0] f_wd;
  logic [31:0] f_rdata;
  logic        f_busy, f_wr;
  logic [7:0]  f_din, f_dout;
  logic [15:0] f_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NCH(3), .ARB_MODE(1), .AW(16)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .req_i(req), .we_i(we), .size_i(sz_v), .addr_i(ad_v), .wdata_i(wd_v),
    .abort_i(abt), .done_o(done), .rdata_o(rdata), .busy_o(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  mem_port_arbiter #(.NCH(2), .ARB_MODE(0), .AW(16)) dut_fp (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .req_i(f_req), .we_i(f_we), .size_i(f_sz), .addr_i(f_ad), .wdata_i(f_wd),
    .abort_i(f_abt), .done_o(f_done), .rdata_o(f_rdata), .busy_o(f_busy),
    .mem_din(f_din), .mem_dout(f_dout), .mem_a(f_a), .mem_wr(f_wr)
  );

  // Memory contents as a pure function of address; 0x1000..0x1003 = 11 22 33 44.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [3:0] lo;
    lo = a[3:0] + 4'd1;
    return {lo, lo} ^ a[11:4];
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) mem_din <= mem_byte(mem_a);

  function automatic bit rhigh(input int r, input int s, input int l);
    return !(l > 0 && r >= s && r < s + l);
  endfunction

  function automatic int oh2i(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 9;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input bit w, input logic [1:0] s,
                        input logic [15:0] a, input logic [31:0] d);
    req[ch]          = 1'b1;
    we[ch]           = w;
    sz_v[2*ch +: 2]  = s;
    ad_v[16*ch +: 16] = a;
    wd_v[32*ch +: 32] = d;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One transfer on the RR instance, started from IDLE at posedge+1.
  // st_at/st_len: rdy_in low window (relative to grant cycle 0);
  // ab_at: cycle abort_i[ch] is pulsed (0 = none); noise: random aborts on another channel.
  task automatic run_xfer(input string tag, input int ch, input bit w, input logic [1:0] s,
                          input logic [15:0] a, input logic [31:0] d, input int st_at,
                          input int st_len, input int ab_at, input bit noise);
    int n, lat, done_exp, hc, got_r, stop_r, other;
    bit aborted, wr_stall, rd_nz, busy_after;
    logic [2:0]  got_done, exp_done;
    logic [31:0] got_rdata, exp_rd;
    logic [15:0] ak;
    logic [23:0] wq[$];
    logic [15:0] aq[$];
    n   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    lat = w ? n + 1 : n + 2;
    hc = 0;
    done_exp = -1;
    for (int r = 1; r < 100 && done_exp < 0; r++) begin
      if (rhigh(r, st_at, st_len)) hc++;
      if (hc == lat) done_exp = r;
    end
    aborted = !w && ab_at > 0 && ab_at < done_exp && rhigh(ab_at, st_at, st_len);
    exp_rd = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 16'(k);
      exp_rd[8*k +: 8] = mem_byte(ak);
    end
    exp_done = 3'b001 << ch;
    stop_r = aborted ? ab_at + 1 : done_exp + 1;
    other  = (ch + 1) % 3;
    req = '0;
    abt = '0;
    set_ch(ch, w, s, a, d);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    tick();
    req[ch] = 1'b0;
    we[ch]  = 1'($urandom);
    sz_v[2*ch +: 2]   = 2'($urandom);
    ad_v[16*ch +: 16] = 16'($urandom);
    wd_v[32*ch +: 32] = $urandom;
    hc = 0; got_r = -1; got_done = '0; got_rdata = '0;
    wr_stall = 0; rd_nz = 0; busy_after = 1;
    for (int r = 1; r <= stop_r; r++) begin
      rdy = rhigh(r, st_at, st_len);
      abt[ch] = (r == ab_at);
      if (noise) abt[other] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_wr && !rdy) wr_stall = 1;
      if (mem_wr) wq.push_back({mem_a, mem_dout});
      if (!w && busy && rdy) begin
        hc++;
        if (hc <= n) aq.push_back(mem_a);
      end
      if (done != 0 && got_r < 0) begin
        got_r = r; got_done = done; got_rdata = rdata;
      end
      if (aborted && rdata != 0) rd_nz = 1;
      if (aborted && r == stop_r) busy_after = busy;
      tick();
    end
    rdy = 1'b1;
    abt = '0;
    chk({tag, "_wr_in_stall"}, wr_stall, 1'b0);
    if (aborted) begin
      chk({tag, "_abort_no_done"}, got_r, -1);
      chk({tag, "_abort_idle"}, busy_after, 1'b0);
      chk({tag, "_abort_rdata0"}, rd_nz, 1'b0);
    end else begin
      chk({tag, "_done_cycle"}, got_r, done_exp);
      chk({tag, "_done_vec"}, got_done, exp_done);
      if (w) begin
        chk({tag, "_wr_count"}, wq.size(), n);
        for (int k = 0; k < n && k < wq.size(); k++) begin
          ak = a + 16'(k);
          chk({tag, "_wr_byte"}, wq[k], {ak, d[8*k +: 8]});
        end
      end else begin
        chk({tag, "_rdata"}, got_rdata, exp_rd);
        chk({tag, "_rd_count"}, aq.size(), n);
        for (int k = 0; k < n && k < aq.size(); k++) begin
          ak = a + 16'(k);
          chk({tag, "_rd_addr"}, aq[k], ak);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int gm[$];
    int gf[$];
    bit seen_done, seen_busy;
    int ch, n, sa, sl, ab;
    bit w;
    logic [1:0] s;

    rst = 1'b0; rdy = 1'b1;
    req = '0; we = '0; abt = '0; sz_v = '0; ad_v = '0; wd_v = '0;
    f_req = '0; f_we = '0; f_abt = '0; f_sz = '0; f_ad = '0; f_wd = '0; f_din = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 3'b000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_a", mem_a, 16'h0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_dout", mem_dout, 8'h0);
    tick();
    rst = 1'b1;

    // Both arbitration modes with ch0 and ch1 held high (1-byte writes).
    set_ch(0, 1'b1, 2'b00, 16'h4000, 32'h0000_0011);
    set_ch(1, 1'b1, 2'b00, 16'h4100, 32'h0000_0022);
    f_req = 2'b11; f_we = 2'b11; f_sz = '0; f_ad = {16'h4100, 16'h4000};
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      if (done != 0) gm.push_back(oh2i(done));
      if (f_done != 0) gf.push_back(oh2i({1'b0, f_done}));
      tick();
    end
    req = '0; f_req = '0;
    repeat (4) tick();
    chk("rr_count", gm.size() >= 3, 1'b1);
    chk("rr_g0", gm.size() > 0 ? gm[0] : 99, 0);
    chk("rr_g1", gm.size() > 1 ? gm[1] : 99, 1);
    chk("rr_g2", gm.size() > 2 ? gm[2] : 99, 0);
    chk("fp_count", gf.size() >= 3, 1'b1);
    chk("fp_g0", gf.size() > 0 ? gf[0] : 99, 0);
    chk("fp_g1", gf.size() > 1 ? gf[1] : 99, 0);
    chk("fp_g2", gf.size() > 2 ? gf[2] : 99, 0);

    // Directed transfers.
    run_xfer("word_read", 0, 1'b0, 2'b10, 16'h1000, 32'h0, 0, 0, 0, 1'b0);
    run_xfer("half_write", 1, 1'b1, 2'b01, 16'h2001, 32'hAABBCCDD, 0, 0, 0, 1'b0);
    run_xfer("read_stall", 0, 1'b0, 2'b10, 16'h1000, 32'h0, 3, 3, 0, 1'b0);
    run_xfer("write_wrap_stall", 2, 1'b1, 2'b11, 16'hFFFE, 32'h8765_4321, 2, 2, 0, 1'b0);
    run_xfer("read_wrap", 2, 1'b0, 2'b11, 16'hFFFD, 32'h0, 0, 0, 0, 1'b0);
    run_xfer("write_abort_ign", 1, 1'b1, 2'b10, 16'h0500, 32'h0102_0304, 0, 0, 2, 1'b0);
    run_xfer("byte_read", 1, 1'b0, 2'b00, 16'h0777, 32'h0, 0, 0, 0, 1'b1);
    run_xfer("fin_stall", 0, 1'b0, 2'b01, 16'h0123, 32'h0, 4, 2, 0, 1'b0);

    // Abort of ch0 read at k=1; pending ch1 is granted the cycle after.
    reset_dut();
    req = '0;
    set_ch(0, 1'b0, 2'b10, 16'h1000, 32'h0);
    set_ch(1, 1'b1, 2'b00, 16'h3000, 32'h0000_005A);
    @(negedge clk);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("ab_busy_r1", busy, 1'b1);
    tick();
    abt[0] = 1'b1;
    @(negedge clk);
    chk("ab_done_r2", done, 3'b000);
    tick();
    abt[0] = 1'b0;
    @(negedge clk);
    chk("ab_idle_r3", busy, 1'b0);
    chk("ab_done_r3", done, 3'b000);
    chk("ab_rdata_r3", rdata, 32'h0);
    tick();
    req[1] = 1'b0;
    @(negedge clk);
    chk("ab_ch1_busy", busy, 1'b1);
    chk("ab_ch1_wr", mem_wr, 1'b1);
    chk("ab_ch1_addr", mem_a, 16'h3000);
    chk("ab_ch1_data", mem_dout, 8'h5A);
    tick();
    @(negedge clk);
    chk("ab_ch1_done", done, 3'b010);
    tick();
    tick();

    // Request and abort together in IDLE: the request is granted.
    req = '0;
    set_ch(2, 1'b0, 2'b00, 16'h1005, 32'h0);
    abt[2] = 1'b1;
    @(negedge clk);
    tick();
    req[2] = 1'b0;
    abt[2] = 1'b0;
    @(negedge clk);
    chk("reqab_busy", busy, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("reqab_done", done, 3'b100);
    chk("reqab_rdata", rdata, {24'h0, mem_byte(16'h1005)});
    tick();
    tick();

    // Reset asserted at k=2 of a word read.
    req = '0;
    set_ch(0, 1'b0, 2'b10, 16'h1000, 32'h0);
    @(negedge clk);
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 3'b000);
    chk("mrst_rdata", rdata, 32'h0);
    chk("mrst_mem_a", mem_a, 16'h0);
    chk("mrst_mem_wr", mem_wr, 1'b0);
    chk("mrst_mem_dout", mem_dout, 8'h0);
    tick();
    tick();
    rst = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if (done != 0) seen_done = 1;
      if (busy) seen_busy = 1;
      tick();
    end
    chk("mrst_no_done", seen_done, 1'b0);
    chk("mrst_no_busy", seen_busy, 1'b0);

    // Randomized transfers.
    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(0, 2);
      w  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      n  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
      sa = 0; sl = 0; ab = 0;
      if ($urandom_range(0, 1) == 1) begin
        sa = $urandom_range(1, 5);
        sl = $urandom_range(1, 3);
      end
      if (!w && $urandom_range(0, 9) < 3) ab = $urandom_range(1, n + 1);
      run_xfer("rand", ch, w, s, 16'($urandom), $urandom, sa, sl, ab, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NCH, default 2: number of requestor channels, range 2..8.
REQ-002 Parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 Parameter AW, default 32: address width.
REQ-004 Port clk_in  input  1: single clock, rising edge.
REQ-005 Port rst_in  input  1: asynchronous, active-low reset.
REQ-006 Port rdy_in  input  1: when low, the block freezes.
REQ-007 Port req_i  input  NCH: per-channel request level.
REQ-008 Port we_i  input  NCH: per-channel write enable; 1 = write.
REQ-009 Port size_i  input  2*NCH: per-channel size code; 00 = 1 byte, 01 = 2 bytes, 10 and 11 = 4 bytes.
REQ-010 Port addr_i  input  AW*NCH: per-channel byte base address.
REQ-011 Port wdata_i  input  32*NCH: per-channel write data, little-endian.
REQ-012 Port abort_i  input  NCH: per-channel abort, used for IF flush.
REQ-013 Port done_o  output  NCH: one-cycle completion pulse per channel.
REQ-014 Port rdata_o  output  32: read data, zero-extended; valid only while a done_o bit is high.
REQ-015 Port busy_o  output  1: transfer in progress.
REQ-016 Port mem_din  input  8: memory read byte.
REQ-017 Port mem_dout  output  8: memory write byte.
REQ-018 Port mem_a  output  AW: memory byte address.
REQ-019 Port mem_wr  output  1: memory write strobe; 1 = write.

Function
REQ-020 Memory model: the byte at the address driven in cycle t appears on mem_din in cycle t+1.
REQ-021 FSM states: IDLE, XFER, FIN.
- IDLE: busy_o=0, mem_wr=0, mem_a=0.
REQ-022 IDLE with any eligible req_i high:
- select a winner per ARB_MODE;
- latch that channel's we, size, addr and wdata;
- clear byte counter cnt;
- go to XFER at the next edge.
REQ-023 Round-robin: search starts at index (last granted + 1) mod NCH; pointer updates on each grant.
REQ-024 XFER, per issue cycle k (0 <= k < n bytes):
- mem_a = base + k, wrapping mod 2^AW;
- mem_wr = latched we;
- mem_dout = wdata[8k+7:8k].
REQ-025 Read capture: byte k is taken from mem_din one cycle after its issue cycle and placed in rdata[8k+7:8k].
- Upper unused bytes are zero.
REQ-026 Write exits XFER after issuing byte n-1; read exits XFER after capturing byte n-1; both go to FIN.
REQ-027 FIN lasts one cycle:
- done_o[winner]=1; rdata_o valid;
- FSM behaves as IDLE and may arbitrate;
- the channel just completed is masked from arbitration in that cycle.
REQ-028 Latency from the IDLE cycle that grants (cycle T):
- read of n bytes: done_o high in cycle T+n+2;
- write of n bytes: done_o high in cycle T+n+1.
REQ-029 Inputs of the granted channel may change after the grant cycle; latched values are used.
REQ-030 abort_i[winner] high during a read in XFER:
- the next edge returns to IDLE;
- no done_o pulse; rdata_o stays 0.
REQ-031 abort_i during a write is ignored; the write always completes.
REQ-032 abort_i on a non-granted channel has no effect; it does not cancel pending req_i.
REQ-033 rdy_in low:
- all state, counters and the RR pointer hold;
- mem_wr is forced 0; no capture occurs;
- done_o is held 0 and the FIN pulse is deferred.
REQ-034 A byte issued in a cycle with rdy_in low does not count as issued; it is re-issued after rdy_in returns high, and capture follows the re-issue.
REQ-035 Simultaneous req_i and abort_i on the same channel while in IDLE: the request is granted.

Reset
REQ-036 While rst_in=0, asynchronously:
- state = IDLE, cnt = 0, RR pointer = 0;
- done_o = 0, rdata_o = 0, busy_o = 0;
- mem_a = 0, mem_wr = 0, mem_dout = 0.
REQ-037 Reset asserted mid-transfer abandons the transfer; no done_o follows the release of reset.
REQ-038 The first edge after release may grant.

Verification
REQ-039 Word read: ch0 read, size 10, addr 0x1000, memory bytes 11 22 33 44 -> mem_a 0x1000..0x1003 on consecutive cycles; done_o[0] at T+6; rdata_o = 0x44332211.
REQ-040 Half write: ch1 write, size 01, addr 0x2001, wdata 0xAABBCCDD -> mem_wr=1 with (0x2001, DD), then (0x2002, CC); done_o[1] at T+3.
REQ-041 Round-robin: ch0 and ch1 both held high, ARB_MODE=1 -> grants ch0, ch1, ch0; with ARB_MODE=0 -> ch0 on every grant.
REQ-042 Abort: ch0 word read aborted at k=1 -> no done_o; block back in IDLE next cycle; ch1 pending request granted the cycle after.
REQ-043 rdy_in stall: rdy_in low for 3 cycles at k=2 of a word read -> mem_wr=0 during the stall; rdata_o correct; done_o delayed by exactly 3 cycles.
REQ-044 Reset mid-read: rst_in low at k=2 -> all outputs 0 immediately; no done_o after release.
